gr_rotate: RTL and testbench
============================

# gr_rotate

Givens-rotation (GR) cell of the QR systolic array: the consumer of the 3-bit rotation-direction stream emitted by the Givens-generation cell. It holds one element of the triangular R row and rotates each streamed element against it using 12 CORDIC micro-rotations (3 per clock, 4-clock frame). It forwards directions and frame flags to the next GR cell to the right, and emits the rotated residual downward.

## Interface
Parameters:
- SHIFT_VALID, 4, fractional guard bits added on input, removed on output
- K_SCALE, 9'd155, CORDIC gain compensation (×155/256)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- data_in  in  13  signed streamed element; sampled on load edges only
- di_in  in  3  direction bits for the current phase; bit j = iteration 3·phase+j
- first  in  1  frame-start tag: load R element, no rotation
- last_end_in  in  1  frame tag: drain R element
- data_out  out  13  signed rotated residual (or drained R), registered
- di_out  out  3  di_in delayed 4 clocks
- first_out  out  1  first delayed 4 clocks
- last_out  out  1  last_end_in delayed 4 clocks

## Operation
- 2-bit phase counter: reset value 3, increments each clock and wraps 3→0. A clock edge with phase==3 is a **load edge**.
- State: r (26-bit signed R element), working x, y (26-bit), frame mode {ROT, LOAD, DRAIN}, dout (26-bit). All reset to 0; mode resets to ROT.
- Micro-rotation i with bit d: d=1 → x'=x−(y>>>i), y'=y+(x>>>i); d=0 → x'=x+(y>>>i), y'=y−(x>>>i). Arithmetic right shift, 26-bit wrap. In phase p, iterations i=3p, 3p+1, 3p+2 are chained combinationally and written to x, y at the edge ending phase p, except at phase 3, where the load edge consumes them as xf, yf.
- In LOAD and DRAIN modes, x and y hold.
- Scaling: s(v) = (v·K_SCALE)>>>8. The product is computed at 35 bits and truncated to 26 bits.
- At each load edge, the closing frame's mode is applied first:
  - ROT: r←s(xf), dout←s(yf).
  - LOAD: r unchanged, dout←0.
  - DRAIN: dout←r, r←0.
- Then the new frame is set up:
  - last_end_in=1: mode DRAIN. This takes priority over first.
  - Else first=1: mode LOAD, r←data_in<<<4.
  - Else mode ROT, x←(updated r), y←data_in<<<4.
- data_out = dout>>>SHIFT_VALID, low 13 bits.
- di_out, first_out and last_out are 4-deep shift registers, so the right-hand neighbour with an identically reset counter sees them in its matching phase.

## Timing
- Reset (async): all outputs 0 immediately; phase=3, so the first edge after reset deasserts is a load edge.
- Latency: data_in sampled at load edge E appears on data_out after edge E+4, and is stable for 4 clocks.
- di_in is used combinationally in the same cycle; upstream guarantees alignment with this cell's phase.
- first and last_end_in are ignored on non-load edges.
- Simultaneous first and last_end_in: DRAIN.
- Reset mid-frame discards r, the partial rotation and all delay lines. No output glitch beyond the async clear.
- Overflow: modular 26-bit. Inputs are bounded to 13-bit signed so growth (×1.65) stays in range.

## Configuration
- GR_ROUND_EN defined: data_out = (dout + 2^(SHIFT_VALID−1))>>>SHIFT_VALID, i.e. round-half-up.
- GR_ROUND_EN undefined: plain truncating arithmetic shift.
- Delay lines and internal state are identical in both builds.

## Test plan
- Reset: assert reset mid-frame with r≠0 → data_out, di_out, first_out, last_out = 0 at once. After release, data_out stays 0 for 4 clocks.
- Load: first=1, data_in=100 at load edge → r=1600; data_out=0 after the next load edge.
- Rotate: r=100 loaded, then data_in=100 with di_in per phase = the 12 vectoring directions of (100,100) → data_out ∈ [−1,1]; the following DRAIN outputs 140–142.
- Drain: last_end_in=1 with r=1600 → data_out=100 for one frame, then r=0 (the next drain outputs 0).
- Forwarding: di_in=3'b101, first=1, last_end_in=1 at clock t → di_out=3'b101, first_out=1, last_out=1 at t+4 only.
- Rounding: dout=24 → data_out=2 with GR_ROUND_EN, 1 without. dout=−24 → −1 with, −2 without.

Source files
------------

// File: rtl/gr_rotate_if.sv
// Streaming bundle between neighbouring Givens-rotation cells:
// element, per-phase direction bits and frame tags in, their forwarded copies out.
interface gr_rotate_if;
  logic signed [12:0] data_in;
  logic        [2:0]  di_in;
  logic               first;
  logic               last_end_in;
  logic signed [12:0] data_out;
  logic        [2:0]  di_out;
  logic               first_out;
  logic               last_out;

  modport master (output data_in, di_in, first, last_end_in,
                  input  data_out, di_out, first_out, last_out);
  modport slave  (input  data_in, di_in, first, last_end_in,
                  output data_out, di_out, first_out, last_out);
endinterface

// File: rtl/gr_rotate.sv
// Givens-rotation cell: rotates streamed elements against a held R element with
// 12 CORDIC micro-rotations over a 4-clock frame. Define GR_ROUND_EN for round-half-up output.
module gr_rotate #(
  parameter int         SHIFT_VALID = 4,
  parameter logic [8:0] K_SCALE     = 9'd155
) (
  input logic        clk,
  input logic        reset,
  gr_rotate_if.slave gr
);

  typedef enum logic [1:0] {MODE_ROT, MODE_LOAD, MODE_DRAIN} mode_e;
  typedef struct packed {
    logic [25:0] x;
    logic [25:0] y;
  } vec_t;

  function automatic vec_t micro_rot(input vec_t v, input logic d, input logic [3:0] sh);
    logic signed [25:0] xs, ys, xsh, ysh;
    vec_t o;
    xs  = v.x;
    ys  = v.y;
    xsh = xs >>> sh;
    ysh = ys >>> sh;
    o.x = d ? xs - ysh : xs + ysh;
    o.y = d ? ys + xsh : ys - xsh;
    return o;
  endfunction

  // Gain compensation: full 35-bit product, then floor-divide by 256 and wrap to 26 bits.
  function automatic logic signed [25:0] scale(input logic signed [25:0] v);
    logic signed [34:0] prod;
    prod = 35'(v) * 35'($signed({1'b0, K_SCALE}));
    return 26'(prod >>> 8);
  endfunction

  logic        [1:0]  phase_q, phase_d;
  mode_e              mode_q, mode_d;
  logic signed [25:0] r_q, r_d;
  logic signed [25:0] x_q, x_d;
  logic signed [25:0] y_q, y_d;
  logic signed [25:0] dout_q, dout_d;
  logic [3:0][4:0]    fwd_q, fwd_d;

  logic        [3:0]  sh_base;
  logic signed [25:0] data_ext;
  logic signed [25:0] r_upd;
  vec_t               v0, v1, v2, v3;

  assign sh_base  = 4'(phase_q) * 4'd3;
  assign data_ext = 26'(gr.data_in) <<< SHIFT_VALID;

  assign v0 = {x_q, y_q};
  assign v1 = micro_rot(v0, gr.di_in[0], sh_base);
  assign v2 = micro_rot(v1, gr.di_in[1], sh_base + 4'd1);
  assign v3 = micro_rot(v2, gr.di_in[2], sh_base + 4'd2);

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch can be inferred.
    phase_d = phase_q + 2'd1;
    mode_d  = mode_q;
    r_d     = r_q;
    x_d     = x_q;
    y_d     = y_q;
    dout_d  = dout_q;
    r_upd   = r_q;
    fwd_d   = {fwd_q[2:0], {gr.di_in, gr.first, gr.last_end_in}};

    if (phase_q == 2'd3) begin
      case (mode_q)
        MODE_LOAD: begin
          r_upd  = r_q;
          dout_d = '0;
        end
        MODE_DRAIN: begin
          r_upd  = '0;
          dout_d = r_q;
        end
        default: begin
          r_upd  = scale($signed(v3.x));
          dout_d = scale($signed(v3.y));
        end
      endcase

      // A drain tag wins over a load tag arriving on the same edge.
      if (gr.last_end_in) begin
        mode_d = MODE_DRAIN;
        r_d    = r_upd;
      end else if (gr.first) begin
        mode_d = MODE_LOAD;
        r_d    = data_ext;
      end else begin
        mode_d = MODE_ROT;
        r_d    = r_upd;
        x_d    = r_upd;
        y_d    = data_ext;
      end
    end else if (mode_q == MODE_ROT) begin
      x_d = v3.x;
      y_d = v3.y;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= 2'd3;
      mode_q  <= MODE_ROT;
      r_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dout_q  <= '0;
      // NOTE: the tag delay line is cleared too, so the neighbour never sees stale tags after reset.
      fwd_q   <= '0;
    end else begin
      phase_q <= phase_d;
      mode_q  <= mode_d;
      r_q     <= r_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dout_q  <= dout_d;
      fwd_q   <= fwd_d;
    end
  end

  assign {gr.di_out, gr.first_out, gr.last_out} = fwd_q[3];

`ifdef GR_ROUND_EN
  localparam logic signed [25:0] RND_BIAS = 26'sd1 <<< (SHIFT_VALID - 1);
  assign gr.data_out = 13'((dout_q + RND_BIAS) >>> SHIFT_VALID);
`else
  assign gr.data_out = 13'(dout_q >>> SHIFT_VALID);
`endif

endmodule

// File: tb/tb_gr_rotate.sv
// Directed bench for gr_rotate: load, rotate, drain, tag forwarding, rounding and mid-frame reset,
// with hand-computed CORDIC results.
module tb_gr_rotate;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [4:0]         fwd_hist [4];
  logic signed [12:0] exp_prev;

`ifdef GR_ROUND_EN
  localparam logic signed [12:0] EXP_ROT_POS = 13'sd0;
  localparam logic signed [12:0] EXP_POS24   = 13'sd2;
  localparam logic signed [12:0] EXP_NEG24   = -13'sd1;
`else
  localparam logic signed [12:0] EXP_ROT_POS = -13'sd1;
  localparam logic signed [12:0] EXP_POS24   = 13'sd1;
  localparam logic signed [12:0] EXP_NEG24   = -13'sd2;
`endif

  always #5 clk = ~clk;

  gr_rotate_if gif ();

  gr_rotate dut (
    .clk   (clk),
    .reset (reset),
    .gr    (gif)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_hist();
    for (int k = 0; k < 4; k++) fwd_hist[k] = '0;
  endtask

  // One clock: drive inputs, take the edge, then compare the forwarded tags with the input 4 clocks back.
  task automatic cyc(input logic [2:0] di, input logic f, input logic l, input logic signed [12:0] d);
    gif.di_in       = di;
    gif.first       = f;
    gif.last_end_in = l;
    gif.data_in     = d;
    for (int k = 3; k > 0; k--) fwd_hist[k] = fwd_hist[k-1];
    fwd_hist[0] = {di, f, l};
    @(posedge clk);
    #1;
    check("fwd", {gif.di_out, gif.first_out, gif.last_out}, fwd_hist[3]);
  endtask

  // Four phases of a frame; dirs bit i is micro-rotation i. The phase-3 clock carries the next frame's tags.
  task automatic frame(input string tag, input logic [11:0] dirs, input logic f, input logic l,
                       input logic signed [12:0] d, input logic signed [12:0] exp, input logic noise);
    for (int p = 0; p < 3; p++) begin
      cyc(dirs[3*p +: 3], noise, 1'b0, noise ? 13'sd7 : 13'sd0);
      check({tag, "_hold"}, gif.data_out, exp_prev);
    end
    cyc(dirs[11:9], f, l, d);
    check(tag, gif.data_out, exp);
    exp_prev = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    gif.data_in     = '0;
    gif.di_in       = '0;
    gif.first       = 1'b0;
    gif.last_end_in = 1'b0;
    exp_prev        = '0;
    clear_hist();
    #2;
    check("rst_dout", gif.data_out, 13'sd0);
    check("rst_fwd", {gif.di_out, gif.first_out, gif.last_out}, 5'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First edge after reset is a load edge: load R = 100.
    cyc(3'b000, 1'b1, 1'b0, 13'sd100);
    check("prime", gif.data_out, 13'sd0);

    frame("load_out",  12'h000, 1'b0, 1'b0, 13'sd100, 13'sd0,   1'b0);
    // Vectoring (1600,1600): xf=3727 -> r=2256, yf=1 -> residual 0.
    frame("rot_resid", 12'h07C, 1'b0, 1'b1, 13'sd0,   13'sd0,   1'b0);
    frame("drain_r",   12'h000, 1'b0, 1'b1, 13'sd0,   13'sd141, 1'b0);
    frame("drain_clr", 12'h000, 1'b1, 1'b0, 13'sd100, 13'sd0,   1'b0);
    // Stray load tags on non-load edges must be ignored.
    frame("load2",     12'h000, 1'b0, 1'b1, 13'sd0,   13'sd0,   1'b1);
    // first+last together: drain wins; di=101 on this clock checks forwarding.
    frame("drain_prio", 12'hA00, 1'b1, 1'b1, 13'sd55, 13'sd100, 1'b0);

    for (int p = 0; p < 4; p++) begin
      cyc(3'b000, p == 3, 1'b0, (p == 3) ? 13'sd1 : 13'sd0);
      check("fwd_t4", {gif.di_out, gif.first_out, gif.last_out}, (p == 2) ? 5'b10111 : 5'b00000);
      check("drain_prio_clr", gif.data_out, (p == 3) ? 13'sd0 : 13'sd100);
    end
    exp_prev = 13'sd0;

    // (16,16): xf=41 -> r=24, yf=-1 -> dout=-1.
    frame("load16",   12'h000, 1'b0, 1'b0, 13'sd1,   13'sd0,      1'b0);
    frame("rot_pos",  12'h3FC, 1'b0, 1'b1, 13'sd0,   EXP_ROT_POS, 1'b0);
    frame("rnd_pos",  12'h000, 1'b1, 1'b0, -13'sd1,  EXP_POS24,   1'b0);
    // (-16,-16): xf=-39 -> r=-24, yf=4 -> dout=2.
    frame("load_neg", 12'h000, 1'b0, 1'b0, -13'sd1,  13'sd0,      1'b0);
    frame("rot_neg",  12'h03C, 1'b0, 1'b1, 13'sd0,   13'sd0,      1'b0);
    frame("rnd_neg",  12'h000, 1'b0, 1'b0, 13'sd0,   EXP_NEG24,   1'b0);
    frame("rot_zero", 12'h000, 1'b1, 1'b0, 13'sd100, 13'sd0,      1'b0);
    frame("load3",    12'h000, 1'b0, 1'b1, 13'sd0,   13'sd0,      1'b0);
    frame("drain3",   12'hA00, 1'b1, 1'b0, 13'sd50,  13'sd100,    1'b0);

    // Mid-frame reset with r=800, data_out=100 and a nonzero tag at the delay-line output.
    for (int p = 0; p < 3; p++) begin
      cyc(3'b101, 1'b1, 1'b1, 13'sd0);
      check("noload_tag", gif.data_out, 13'sd100);
    end
    #3;
    reset = 1'b1;
    #1;
    check("midrst_dout", gif.data_out, 13'sd0);
    check("midrst_fwd", {gif.di_out, gif.first_out, gif.last_out}, 5'd0);
    clear_hist();
    @(posedge clk);
    #1;
    reset = 1'b0;

    exp_prev = 13'sd0;
    cyc(3'b000, 1'b0, 1'b1, 13'sd0);
    check("post_rst", gif.data_out, 13'sd0);
    frame("post_rst_drain", 12'h000, 1'b0, 1'b0, 13'sd0, 13'sd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
